count_hex_scanner: RTL

//   Downstream display stage for the 8-bit free-running counter value. Samples
//   the count once per scan frame into a shadow register, so both digits always

---
 rtl/count_hex_scanner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/count_hex_scanner.sv
// ---------------------------------------------------------------------------
// count_hex_scanner
//
// Display stage for an 8-bit counter value. Drives a two-digit, time-
// multiplexed common-cathode 7-segment display: the low nibble goes to digit 0
// and the high nibble to digit 1. A shadow register samples count_in once per
// scan frame, so both digits always show the same value. Each digit slot
// starts with a blank interval to suppress ghosting.
//
// Parameters
//   SCAN_DIV      clocks per digit slot (>= 2)
//   BLANK_CYCLES  clocks with segments forced off at the start of each slot
//                 (0 .. SCAN_DIV-1)
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   count_in    in   [7:0] value to display
//   seg         out  [6:0] segments {g,f,e,d,c,b,a}, active high
//   dig_en      out  [1:0] one-hot digit enable, [0]=low nibble, [1]=high nibble
//   frame_tick  out  one-cycle pulse on the edge that loads the shadow register
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, a zero high nibble is shown blank
//                          (digit 0 is never suppressed)
// ---------------------------------------------------------------------------
module count_hex_scanner #(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  localparam int              PW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   P_LAST = PW'(SCAN_DIV - 1);

  // Scan state
  logic [PW-1:0] p_q, p_d;
  logic          d_q, d_d;
  logic [7:0]    shadow_q, shadow_d;

  // Registered outputs
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_en_q, dig_en_d;
  logic          frame_tick_q, frame_tick_d;

  logic          wrap;
  logic          load;
  logic          blank_d;
  logic [3:0]    nibble_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next-state logic. The shadow loads when the digit toggles from 1 back to
  // 0, i.e. at the start of every frame.
  always_comb begin
    wrap         = (p_q == P_LAST);
    load         = wrap && d_q;
    p_d          = wrap ? '0 : p_q + 1'b1;
    d_d          = wrap ? ~d_q : d_q;
    shadow_d     = load ? count_in : shadow_q;
    frame_tick_d = load;
  end

  // With no blanking the compare against zero would be constant, so it is
  // left out of the build entirely.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_d = 1'b0;
    end else begin : g_blank
      localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
      assign blank_d = (p_d < P_BLANK);
    end
  endgenerate

  // Output decode from the next state, so registered outputs line up with the
  // state they describe on the same edge.
  always_comb begin
    nibble_d = d_d ? shadow_d[7:4] : shadow_d[3:0];
    dig_en_d = d_d ? 2'b10 : 2'b01;
    seg_d    = hex7(nibble_d);
    if (blank_d) begin
      seg_d = 7'h00;
    end
`ifdef LEADING_ZERO_BLANK_EN
    else if (d_d && (shadow_d[7:4] == 4'h0)) begin
      seg_d = 7'h00;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q          <= '0;
      d_q          <= 1'b0;
      shadow_q     <= 8'h00;
      seg_q        <= 7'h00;
      dig_en_q     <= 2'b00;
      frame_tick_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      d_q          <= d_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule
